// File: rtl/seq_add_pkg.sv
// Shared definitions for the sequential wide adder: FSM state encoding and
// default geometry (slice width and slice count).
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SEQ_ADD_DEFAULT_N      = 4;
  localparam int SEQ_ADD_DEFAULT_SLICES = 4;

endpackage

// File: rtl/slice_add.sv
// Purely combinational N-bit adder slice: {cout, sum} = a + b + cin.
// Holds no state; the parent steps it across the operand one slice per cycle.
module slice_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Zero-extend to N+1 bits so the carry falls out of the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/seq_wide_add.sv
// Sequential wide adder: latches two W-bit operands (W = N*SLICES) and adds
// them one N-bit slice per cycle through a single shared slice_add, then
// presents the sum/carry with a valid/ready handshake.
// Optional build macro: SEQ_ADD_OVF_EN adds the out_ovf signed-overflow port.
module seq_wide_add
  import seq_add_pkg::*;
#(
  parameter int N      = SEQ_ADD_DEFAULT_N,
  parameter int SLICES = SEQ_ADD_DEFAULT_SLICES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*SLICES-1:0]   in_a,
  input  logic [N*SLICES-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*SLICES-1:0]   out_sum,
  output logic                  out_cout
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic                  out_ovf
`endif
);

  localparam int W     = N * SLICES;
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_t           state_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  int               slice_base;
  logic [N-1:0]     slice_a;
  logic [N-1:0]     slice_b;
  logic [N-1:0]     slice_sum;
  logic             slice_cout;

  // Select the slice of the latched operands addressed by the running index.
  always_comb begin
    slice_base = int'(idx_reg) * N;
    slice_a    = a_reg[slice_base +: N];
    slice_b    = b_reg[slice_base +: N];
  end

  slice_add #(.N(N)) u_slice_add (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Control FSM plus datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      idx_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= in_a;
            b_reg        <= in_b;
            carry_reg    <= in_cin;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          sum_reg[slice_base +: N] <= slice_sum;
          carry_reg                <= slice_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg      <= slice_cout;
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;

`ifdef SEQ_ADD_OVF_EN
  logic ovf_reg;

  // Signed overflow: like-signed operands whose sum sign differs; decided
  // while the top slice is being added so it is ready together with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid && in_ready_reg) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && idx_reg == LAST_IDX) begin
      ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[N-1] != a_reg[W-1]);
    end
  end

  assign out_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_seq_wide_add.sv
// Directed self-checking bench for seq_wide_add: a 4x4-bit instance for the
// main scenarios and a 1x8-bit instance for the single-slice case.
// Build macro SEQ_ADD_OVF_EN, when defined, also enables out_ovf checks.
module tb_seq_wide_add;

  logic        clk = 1'b0;
  logic        rst;

  // Main DUT: N=4, SLICES=4
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [15:0] in_a, in_b, out_sum;
  logic        out_ovf;

  // Single-slice DUT: N=8, SLICES=1
  logic        s1_in_valid, s1_in_ready, s1_in_cin, s1_out_valid, s1_out_ready, s1_out_cout;
  logic [7:0]  s1_in_a, s1_in_b, s1_out_sum;
  logic        s1_out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_wide_add #(.N(4), .SLICES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SEQ_ADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  seq_wide_add #(.N(8), .SLICES(1)) dut_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_a      (s1_in_a),
    .in_b      (s1_in_b),
    .in_cin    (s1_in_cin),
    .out_valid (s1_out_valid),
    .out_ready (s1_out_ready),
    .out_sum   (s1_out_sum),
    .out_cout  (s1_out_cout)
`ifdef SEQ_ADD_OVF_EN
    ,
    .out_ovf   (s1_out_ovf)
`endif
  );

`ifndef SEQ_ADD_OVF_EN
  assign out_ovf    = 1'b0;
  assign s1_out_ovf = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble them.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    step();
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic check_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    chk({tag, "_sum"}, {16'd0, out_sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
`ifdef SEQ_ADD_OVF_EN
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
`endif
    $display("op %s: sum=%h cout=%b ovf=%b (exp %h %b %b)", tag, out_sum, out_cout, out_ovf, es, ec, eo);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_in_a = '0; s1_in_b = '0; s1_in_cin = 1'b0; s1_out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);

    // 0x1234 + 0x4321 + 1 = 0x5556, latency 4
    accept(16'h1234, 16'h4321, 1'b1);
    chk("op1_busy_ready", {31'd0, in_ready}, 32'd0);
    wait_done("op1_latency", 4);
    check_result("op1", 16'h5556, 1'b0, 1'b0);
    release_result("op1");

    // 0xFFFF + 1: carry ripples through every slice
    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_done("op2_latency", 4);
    check_result("op2", 16'h0000, 1'b1, 1'b0);
    release_result("op2");

    // 0x7FFF + 1: positive overflow
    accept(16'h7FFF, 16'h0001, 1'b0);
    wait_done("op3_latency", 4);
    check_result("op3", 16'h8000, 1'b0, 1'b1);
    release_result("op3");

    // 0x8000 + 0x8000: negative overflow with carry out; then hold 3 cycles
    accept(16'h8000, 16'h8000, 1'b0);
    wait_done("op4_latency", 4);
    check_result("op4", 16'h0000, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_a = 16'h0F0F;
    in_b = 16'h0101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_sum", {16'd0, out_sum}, 32'd0);
      chk("hold_cout", {31'd0, out_cout}, 32'd1);
`ifdef SEQ_ADD_OVF_EN
      chk("hold_ovf", {31'd0, out_ovf}, 32'd1);
`endif
    end
    in_valid = 1'b0;
    release_result("op4");

    // Reset during the second RUN cycle aborts the operation
    accept(16'h1111, 16'h2222, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_sum", {16'd0, out_sum}, 32'd0);
    $display("op abort: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, out_sum);

    // Recovery: 0xA5A5 + 0x5A5A + 1 = 0x10000
    accept(16'hA5A5, 16'h5A5A, 1'b1);
    wait_done("op5_latency", 4);
    check_result("op5", 16'h0000, 1'b1, 1'b0);
    release_result("op5");

    // Single-slice instance: 0xFF + 0x01, one-cycle RUN
    s1_in_valid = 1'b1;
    s1_in_a = 8'hFF;
    s1_in_b = 8'h01;
    s1_in_cin = 1'b0;
    step();
    s1_in_valid = 1'b0;
    s1_in_a = 8'h00;
    chk("s1_busy_valid", {31'd0, s1_out_valid}, 32'd0);
    step();
    chk("s1_latency_valid", {31'd0, s1_out_valid}, 32'd1);
    chk("s1_sum", {24'd0, s1_out_sum}, 32'd0);
    chk("s1_cout", {31'd0, s1_out_cout}, 32'd1);
`ifdef SEQ_ADD_OVF_EN
    chk("s1_ovf", {31'd0, s1_out_ovf}, 32'd0);
`endif
    $display("op s1: sum=%h cout=%b", s1_out_sum, s1_out_cout);
    s1_out_ready = 1'b1;
    step();
    s1_out_ready = 1'b0;
    chk("s1_rel_ready", {31'd0, s1_in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_wide_add.md
SEQ_WIDE_ADD -- requirements
Module: seq_wide_add

Interface
REQ-001 Parameter N, default 4: slice width in bits; the block adds one slice per cycle; N SHALL be at least 1.
REQ-002 Parameter SLICES, default 4: number of slices; SLICES SHALL be at least 1; operand width W = N*SLICES.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_cin  input  1  carry into slice 0.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  W  A+B+cin, modulo 2^W.
REQ-013 out_cout  output  1  carry out of the top slice.
REQ-014 out_ovf  output  1  two's-complement signed overflow; present only with SEQ_ADD_OVF_EN.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch in_a, in_b and in_cin; set slice index=0; go to RUN.
REQ-017 In RUN: in_ready=0, out_valid=0; each cycle, add slice[idx] of A and B plus the running carry, write the N-bit result into out_sum slice idx, register the carry, and increment idx.
REQ-018 RUN to DONE: after the cycle that processes idx=SLICES-1; that carry becomes out_cout.
REQ-019 Latency: handshake accepted at edge T -> out_valid=1 after edge T+SLICES; SLICES=1 gives a one-cycle RUN.
REQ-020 In DONE: out_valid=1, in_ready=0; out_sum, out_cout and out_ovf SHALL hold stable while out_ready=0.
REQ-021 DONE to IDLE: on out_valid&&out_ready; in_ready rises the following cycle; there is no back-to-back overlap.
REQ-022 in_valid during RUN or DONE SHALL be ignored, with no operand change.
REQ-023 Operand changes after acceptance SHALL NOT affect the result.
REQ-024 Slice-index counter width is clog2(SLICES), minimum 1 bit; it SHALL never exceed SLICES-1.

Reset
REQ-025 rst=1 in any state, including mid-RUN, SHALL abort the operation and go to IDLE on that edge.
REQ-026 Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, index=0, carry=0.
REQ-027 rst has priority over every handshake in the same cycle.

Configuration
REQ-028 Macro SEQ_ADD_OVF_EN defined: out_ovf port exists; in DONE it equals (A[W-1]==B[W-1]) && (out_sum[W-1]!=A[W-1]).
REQ-029 Macro SEQ_ADD_OVF_EN undefined: no out_ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-030 Shared package seq_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE encoding) and the default N and SLICES constants.
REQ-031 One sub-module slice_add SHALL hold the combinational N-bit adder (a, b, cin -> sum, cout), instantiated once and reused every RUN cycle.
REQ-032 All registers SHALL reside in seq_wide_add; slice_add SHALL contain no state.

Verification (N=4, SLICES=4, W=16, SEQ_ADD_OVF_EN defined)
REQ-033 Accept 0x1234+0x4321, cin=1 -> out_sum=0x5556, out_cout=0, out_valid exactly 4 cycles after accept.
REQ-034 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1; carry ripples through all 4 slices.
REQ-035 0x7FFF+0x0001 -> out_sum=0x8000, out_ovf=1, out_cout=0.
REQ-036 Result ready with out_ready=0 for 3 cycles -> outputs stable, in_ready=0; new in_valid ignored; IDLE one cycle after out_ready=1.
REQ-037 rst=1 at second RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, out_sum=0; next operation computes correctly.
REQ-038 SLICES=1, N=8: 0xFF+0x01 -> out_sum=0x00, out_cout=1, out_valid one cycle after accept.
